// File: rtl/sram_pipe.sv
// Pipelined single-port SRAM with a valid/ready request port and 1- or 2-cycle read latency.
// Define SRAM_PIPE_CLEAR_EN to zero the whole array after every reset before accepting requests.
module sram_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("sram_pipe: RD_LAT must be 1 or 2");
    end

    logic              ready_reg;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_acc;
    logic              wr_acc;

`ifdef SRAM_PIPE_CLEAR_EN
    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic              busy_reg;

    // Clear walks one address per edge; the edge that writes the top address also enters IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (&clr_addr_reg) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state_reg == CLEAR);
    assign clr_addr = clr_addr_reg;
    assign busy     = busy_reg;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b1;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    assign req_ready = ready_reg;
    assign rd_acc    = req_valid & ready_reg & we_n;
    assign wr_acc    = req_valid & ready_reg & ~we_n;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign mem_we    = clr_we | wr_acc;
    assign mem_waddr = clr_we ? clr_addr : addr;
    assign mem_wdata = clr_we ? '0 : data_in;

    // Array and read register carry no reset so the storage maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_raw_reg;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_acc) begin
            rd_raw_reg <= mem[addr];
        end
    end

    logic [RD_LAT-1:0] vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    logic [DATA_W-1:0] rd_last;
    logic              last_load;

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd_pipe_reg;

        always_ff @(posedge clk) begin
            if (vld_reg[0]) begin
                rd_pipe_reg <= rd_raw_reg;
            end
        end

        assign rd_last   = rd_pipe_reg;
        assign last_load = vld_reg[0];
    end else begin : g_lat1
        assign rd_last   = rd_raw_reg;
        assign last_load = rd_acc;
    end

    // Forces data_out to zero from reset until the output register is loaded by a fresh read.
    logic out_clr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clr_reg <= 1'b1;
        end else if (last_load) begin
            out_clr_reg <= 1'b0;
        end
    end

    assign data_out = out_clr_reg ? '0 : rd_last;
    assign rvalid   = vld_reg[RD_LAT-1];

endmodule

// File: tb/tb_sram_pipe.sv
// Directed bench for sram_pipe: two instances (RD_LAT=1 and RD_LAT=2, ADDR_W=4) share one stimulus stream.
// Build with SRAM_PIPE_CLEAR_EN defined to exercise the clear-after-reset behaviour.
module tb_sram_pipe;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        we_n;
    logic [3:0]  addr;
    logic [15:0] data_in;

    logic        rdy1, rdy2, rv1, rv2, busy1, busy2;
    logic [15:0] do1, do2;

    int checks;
    int errors;

    sram_pipe #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .we_n(we_n), .addr(addr), .data_in(data_in),
        .data_out(do1), .rvalid(rv1), .busy(busy1)
    );

    sram_pipe #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
        .we_n(we_n), .addr(addr), .data_in(data_in),
        .data_out(do2), .rvalid(rv2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        v_valid [24];
    logic        v_we_n  [24];
    logic [3:0]  v_addr  [24];
    logic [15:0] v_data  [24];
    logic        r1_v    [24];
    logic        r2_v    [24];
    logic [15:0] r1_d    [24];
    logic [15:0] r2_d    [24];

    task automatic set_vec(input int i, input logic v, input logic w,
                           input logic [3:0] a, input logic [15:0] d);
        v_valid[i] = v;
        v_we_n[i]  = w;
        v_addr[i]  = a;
        v_data[i]  = d;
    endtask

    // Drives vector i before edge i and records both instances right after edge i.
    task automatic run_stream(input int n);
        for (int i = 0; i < n + 4; i++) begin
            if (i < n) begin
                req_valid = v_valid[i];
                we_n      = v_we_n[i];
                addr      = v_addr[i];
                data_in   = v_data[i];
            end else begin
                req_valid = 1'b0;
                we_n      = 1'b1;
                addr      = 4'h0;
                data_in   = 16'h0000;
            end
            @(negedge clk);
            r1_v[i] = rv1;
            r1_d[i] = do1;
            r2_v[i] = rv2;
            r2_d[i] = do2;
            if (rv1 || rv2)
                $display("  s%0d lat1 rvalid=%b data=%h | lat2 rvalid=%b data=%h", i, rv1, do1, rv2, do2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; we_n = 1'b1; addr = 4'h0; data_in = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (rv1 !== 1'b0 || do1 !== 16'h0000 || rv2 !== 1'b0 || do2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got rv1=%b do1=%h rv2=%b do2=%h, want 0/0000", rv1, do1, rv2, do2);
        end
        rst_n = 1'b1;
        #1;
`ifdef SRAM_PIPE_CLEAR_EN
        checks++;
        if (busy1 !== 1'b1 || rdy1 !== 1'b0 || busy2 !== 1'b1 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_start: got busy=%b/%b ready=%b/%b, want busy=1 ready=0", busy1, busy2, rdy1, rdy2);
        end
        begin
            int waited;
            waited = 0;
            while (rdy1 !== 1'b1 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
                errors++;
                $display("FAIL reset_clear_timeout: got ready=%b/%b after %0d cycles, want 1", rdy1, rdy2, waited);
            end
        end
`else
        checks++;
        if (busy1 !== 1'b0 || rdy1 !== 1'b1 || busy2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got busy=%b/%b ready=%b/%b, want busy=0 ready=1", busy1, busy2, rdy1, rdy2);
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || rdy1 !== 1'b1 || busy2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge: got busy=%b/%b ready=%b/%b, want busy=0 ready=1", busy1, busy2, rdy1, rdy2);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        logic [8:0]  e1, e2;
        logic [15:0] d1 [9];
        logic [15:0] d2 [9];
        set_vec(0, 1'b1, 1'b0, 4'h0, 16'h0000);
        set_vec(1, 1'b1, 1'b0, 4'h1, 16'h0005);
        set_vec(2, 1'b1, 1'b0, 4'h2, 16'h000C);
        set_vec(3, 1'b1, 1'b1, 4'h0, 16'h0000);
        set_vec(4, 1'b1, 1'b1, 4'h1, 16'h0000);
        set_vec(5, 1'b1, 1'b1, 4'h2, 16'h0000);
        run_stream(6);
        e1 = 9'b000111000;
        e2 = 9'b001110000;
        d1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h000C, 16'h000C, 16'h000C, 16'h000C};
        d2 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h000C, 16'h000C, 16'h000C};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (r1_v[i] !== e1[i] || r1_d[i] !== d1[i]) begin
                errors++;
                $display("FAIL b2b_lat1 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r1_v[i], r1_d[i], e1[i], d1[i]);
            end
            checks++;
            if (r2_v[i] !== e2[i] || r2_d[i] !== d2[i]) begin
                errors++;
                $display("FAIL b2b_lat2 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r2_v[i], r2_d[i], e2[i], d2[i]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_raw_hazard();
        logic [8:0]  e1, e2;
        logic [15:0] d1 [9];
        logic [15:0] d2 [9];
        set_vec(0, 1'b1, 1'b0, 4'h3, 16'hBEEF);
        set_vec(1, 1'b1, 1'b1, 4'h3, 16'h0000);
        set_vec(2, 1'b1, 1'b0, 4'h3, 16'h1234);
        set_vec(3, 1'b0, 1'b0, 4'h3, 16'hDEAD);
        set_vec(4, 1'b1, 1'b1, 4'h3, 16'h0000);
        run_stream(5);
        e1 = 9'b000010010;
        e2 = 9'b000100100;
        d1 = '{16'h000C, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        d2 = '{16'h000C, 16'h000C, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (r1_v[i] !== e1[i] || r1_d[i] !== d1[i]) begin
                errors++;
                $display("FAIL raw_lat1 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r1_v[i], r1_d[i], e1[i], d1[i]);
            end
            checks++;
            if (r2_v[i] !== e2[i] || r2_d[i] !== d2[i]) begin
                errors++;
                $display("FAIL raw_lat2 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r2_v[i], r2_d[i], e2[i], d2[i]);
            end
        end
        $display("test_raw_hazard done");
    endtask

    task automatic test_top_addr();
        logic [6:0]  e1, e2;
        logic [15:0] d1 [7];
        logic [15:0] d2 [7];
        set_vec(0, 1'b1, 1'b0, 4'hF, 16'hA5A5);
        set_vec(1, 1'b1, 1'b1, 4'hF, 16'h0000);
        set_vec(2, 1'b1, 1'b1, 4'h0, 16'h0000);
        run_stream(3);
        e1 = 7'b0000110;
        e2 = 7'b0001100;
        d1 = '{16'h1234, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        d2 = '{16'h1234, 16'h1234, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (r1_v[i] !== e1[i] || r1_d[i] !== d1[i]) begin
                errors++;
                $display("FAIL top_lat1 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r1_v[i], r1_d[i], e1[i], d1[i]);
            end
            checks++;
            if (r2_v[i] !== e2[i] || r2_d[i] !== d2[i]) begin
                errors++;
                $display("FAIL top_lat2 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r2_v[i], r2_d[i], e2[i], d2[i]);
            end
        end
        $display("test_top_addr done");
    endtask

    task automatic test_mixed();
        logic [10:0] e1, e2;
        logic [15:0] d1 [11];
        logic [15:0] d2 [11];
        set_vec(0, 1'b1, 1'b0, 4'h5, 16'h0007);
        set_vec(1, 1'b1, 1'b1, 4'h5, 16'h0000);
        set_vec(2, 1'b1, 1'b0, 4'h6, 16'h0009);
        set_vec(3, 1'b1, 1'b1, 4'h6, 16'h0000);
        set_vec(4, 1'b1, 1'b1, 4'h5, 16'h0000);
        set_vec(5, 1'b1, 1'b0, 4'h5, 16'h0001);
        set_vec(6, 1'b1, 1'b1, 4'h5, 16'h0000);
        run_stream(7);
        e1 = 11'b00001011010;
        e2 = 11'b00010110100;
        d1 = '{16'h0000, 16'h0007, 16'h0007, 16'h0009, 16'h0007, 16'h0007,
               16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        d2 = '{16'h0000, 16'h0000, 16'h0007, 16'h0007, 16'h0009, 16'h0007,
               16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (r1_v[i] !== e1[i] || r1_d[i] !== d1[i]) begin
                errors++;
                $display("FAIL mixed_lat1 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r1_v[i], r1_d[i], e1[i], d1[i]);
            end
            checks++;
            if (r2_v[i] !== e2[i] || r2_d[i] !== d2[i]) begin
                errors++;
                $display("FAIL mixed_lat2 s%0d: got rvalid=%b data=%h, want rvalid=%b data=%h", i, r2_v[i], r2_d[i], e2[i], d2[i]);
            end
        end
        $display("test_mixed done");
    endtask

    task automatic test_reset_midflight();
        logic [15:0] exp5;
        req_valid = 1'b1; we_n = 1'b1; addr = 4'h5; data_in = 16'h0000;
        @(posedge clk);
        #2;
        checks++;
        if (rv1 !== 1'b1 || do1 !== 16'h0001 || rv2 !== 1'b0) begin
            errors++;
            $display("FAIL midflight_pre: got rv1=%b do1=%h rv2=%b, want 1/0001/0", rv1, do1, rv2);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rv1 !== 1'b0 || do1 !== 16'h0000 || rv2 !== 1'b0 || do2 !== 16'h0000) begin
            errors++;
            $display("FAIL midflight_async: got rv1=%b do1=%h rv2=%b do2=%h, want 0/0000", rv1, do1, rv2, do2);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SRAM_PIPE_CLEAR_EN
        exp5 = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0 || do2 !== 16'h0000) begin
                errors++;
                $display("FAIL midflight_flush c%0d: got rv1=%b rv2=%b do2=%h, want 0/0/0000", k, rv1, rv2, do2);
            end
        end
`else
        exp5 = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0 || do2 !== 16'h0000) begin
                errors++;
                $display("FAIL midflight_flush c%0d: got rv1=%b rv2=%b do2=%h, want 0/0/0000", k, rv1, rv2, do2);
            end
        end
`endif
        set_vec(0, 1'b1, 1'b1, 4'h5, 16'h0000);
        run_stream(1);
        checks++;
        if (r1_v[0] !== 1'b1 || r1_d[0] !== exp5) begin
            errors++;
            $display("FAIL midflight_reread_lat1: got rvalid=%b data=%h, want 1/%h", r1_v[0], r1_d[0], exp5);
        end
        checks++;
        if (r2_v[1] !== 1'b1 || r2_d[1] !== exp5 || r2_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reread_lat2: got rvalid=%b%b data=%h, want 01/%h", r2_v[0], r2_v[1], r2_d[1], exp5);
        end
        $display("test_reset_midflight done");
    endtask

`ifdef SRAM_PIPE_CLEAR_EN
    task automatic test_clear();
        for (int i = 0; i < 16; i++) begin
            set_vec(i, 1'b1, 1'b0, 4'(i), 16'(i + 16'h0100));
        end
        run_stream(16);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy1 !== (k < 16) || rdy1 !== (k >= 16) || busy2 !== (k < 16) || rdy2 !== (k >= 16)) begin
                errors++;
                $display("FAIL clear_busy c%0d: got busy=%b/%b ready=%b/%b, want busy=%b", k, busy1, busy2, rdy1, rdy2, (k < 16));
            end
        end
        for (int i = 0; i < 16; i++) begin
            set_vec(i, 1'b1, 1'b1, 4'(i), 16'h0000);
        end
        run_stream(16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (r1_v[i] !== 1'b1 || r1_d[i] !== 16'h0000 || r2_v[i+1] !== 1'b1 || r2_d[i+1] !== 16'h0000) begin
                errors++;
                $display("FAIL clear_read a%0d: got lat1 %b/%h lat2 %b/%h, want 1/0000", i, r1_v[i], r1_d[i], r2_v[i+1], r2_d[i+1]);
            end
        end
        $display("test_clear done");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_top_addr();
        test_mixed();
        test_reset_midflight();
`ifdef SRAM_PIPE_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_pipe.md
SRAM_PIPE -- requirements
Module: sram_pipe

Interface
REQ-001 Parameter DATA_W, 16, word width in bits.
REQ-002 Parameter ADDR_W, 12, address width; depth = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, 1, read latency in cycles; legal values 1 or 2, any other value is an elaboration error.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 we_n  input  1  request type; 0 = write, 1 = read.
REQ-009 addr  input  ADDR_W  word address of request.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 data_out  output  DATA_W  read data.
REQ-012 rvalid  output  1  one-cycle strobe: data_out carries a new read result.
REQ-013 busy  output  1  initialisation clear in progress.

Function
REQ-014 A request SHALL be accepted on a rising clk edge where req_valid=1 and req_ready=1; otherwise no request is accepted and addr, we_n and data_in are ignored.
REQ-015 An accepted write SHALL store data_in at mem[addr] on the accepting edge; a write produces no rvalid.
REQ-016 An accepted read SHALL assert rvalid with data_out = mem[addr] exactly RD_LAT cycles after the accepting edge.
REQ-017 Reads SHALL be fully pipelined: one accepted request per cycle, results in acceptance order, with no bubbles.
REQ-018 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-019 data_out SHALL hold the last read result until the next rvalid; it does not change on writes.
REQ-020 Address arithmetic SHALL be modulo 2**ADDR_W; address 2**ADDR_W-1 is a normal location.
REQ-021 The control FSM SHALL have states CLEAR and IDLE; req_ready=1 and busy=0 in IDLE, req_ready=0 and busy=1 in CLEAR.
REQ-022 A mixed read/write stream SHALL be accepted every cycle in IDLE; an in-flight read is unaffected by a following write.

Reset
REQ-023 While rst_n=0, outputs SHALL immediately be data_out=0, rvalid=0, and the read pipeline SHALL be flushed.
REQ-024 A read in flight when rst_n falls SHALL be discarded; no rvalid for it appears after release.
REQ-025 Reset SHALL NOT alter memory contents except through the clear sequence (REQ-027).
REQ-026 Without the clear feature, the FSM SHALL enter IDLE on reset, so req_ready=1 on the first edge after release.

Configuration
REQ-027 With macro SRAM_PIPE_CLEAR_EN defined: reset enters CLEAR, writes 0 to addresses 0..2**ADDR_W-1, one address per cycle from the first edge after release. It then enters IDLE after exactly 2**ADDR_W cycles. A reset during CLEAR restarts the sequence from address 0.
REQ-028 With SRAM_PIPE_CLEAR_EN undefined: no CLEAR state and busy tied 0. Memory contents after power-up are undefined (X in simulation).

Verification (DATA_W=16, ADDR_W=4 unless stated)
REQ-029 RD_LAT=1: write 0x0000@0, 0x0005@1, 0x000C@2 on consecutive cycles, then read 0, 1, 2 back-to-back -> rvalid high 3 consecutive cycles starting 1 cycle after the first read accept; data_out 0x0000, 0x0005, 0x000C.
REQ-030 RD_LAT=2: same stimulus -> same data sequence, starting 2 cycles after the first read accept; data_out holds 0x000C after rvalid drops.
REQ-031 Write 0xBEEF@3, then read @3 on the next cycle, then write 0x1234@3 while that read is in flight -> read returns 0xBEEF; a later read @3 returns 0x1234.
REQ-032 Write 0xA5A5@0xF, read @0xF -> 0xA5A5; location 0x0 unchanged.
REQ-033 Accept a read, then assert rst_n=0 mid-latency (RD_LAT=2) -> data_out=0 and rvalid=0 immediately; no rvalid after release; previously written data still readable.
REQ-034 SRAM_PIPE_CLEAR_EN defined, mem preloaded nonzero: release reset -> busy=1 and req_ready=0 for exactly 16 cycles; reads of 0..15 then return 0x0000. Macro undefined: busy=0 and req_ready=1 on the first cycle after release.
